sar_search: RTL

SAR_SEARCH -- requirements
Module: sar_search

---
 rtl/sar_search.sv | 109 ++++++++++
 1 files changed

// File: rtl/sar_search.sv
// sar_search: successive-approximation (binary) search controller.
// Drives a trial code to an external magnitude comparator and resolves the
// target value MSB first, one bit per cycle, with early exit on "equal".
module sar_search #(
   parameter int WIDTH = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             cmp_l,
   input  logic             cmp_e,
   input  logic             cmp_g,
   output logic [WIDTH-1:0] guess,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             err
);

   // index must address WIDTH bits; keep at least one bit for WIDTH==1
   localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_TEST = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam logic [WIDTH-1:0] GUESS_INIT = WIDTH'(1) << (WIDTH - 1);
   localparam logic [IW-1:0]    IDX_INIT   = IW'(WIDTH - 1);

   logic [1:0]       r_state;
   logic [WIDTH-1:0] r_guess;
   logic [WIDTH-1:0] r_result;
   logic [IW-1:0]    r_idx;
   logic             r_err;

   logic [WIDTH-1:0] w_bit;
   logic [WIDTH-1:0] w_next_bit;
   logic [WIDTH-1:0] w_decided;
   logic             w_onehot;

   // bit under test and the one to try next, as masks (avoids narrow indexing)
   assign w_bit      = WIDTH'(1) << r_idx;
   assign w_next_bit = w_bit >> 1;

   // a valid comparator answer has exactly one of L/E/G high
   assign w_onehot = ( cmp_l & ~cmp_e & ~cmp_g) |
                     (~cmp_l &  cmp_e & ~cmp_g) |
                     (~cmp_l & ~cmp_e &  cmp_g);

   // "less" means the trial bit overshot the target and must be dropped
   assign w_decided = cmp_l ? (r_guess & ~w_bit) : r_guess;

   // search FSM: IDLE waits for start, TEST resolves one bit per edge,
   // DONE is a single-cycle result strobe
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= ST_IDLE;
         r_guess  <= '0;
         r_result <= '0;
         r_idx    <= '0;
         r_err    <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_guess <= GUESS_INIT;
                  r_idx   <= IDX_INIT;
                  r_err   <= 1'b0;
                  r_state <= ST_TEST;
               end
            end
            ST_TEST: begin
               if (!w_onehot) begin
                  // malformed response: report the trial we were on
                  r_err    <= 1'b1;
                  r_result <= r_guess;
                  r_state  <= ST_DONE;
               end else if (cmp_e) begin
                  r_result <= r_guess;
                  r_state  <= ST_DONE;
               end else if (r_idx != '0) begin
                  r_guess <= w_decided | w_next_bit;
                  r_idx   <= r_idx - IW'(1);
               end else begin
                  // last bit decided; the code is complete
                  r_guess  <= w_decided;
                  r_result <= w_decided;
                  r_state  <= ST_DONE;
               end
            end
            ST_DONE: begin
               // start is not looked at here, so a request this cycle is dropped
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   // status decoded from the state register only
   assign busy   = (r_state == ST_TEST);
   assign done   = (r_state == ST_DONE);
   assign guess  = r_guess;
   assign result = r_result;
   assign err    = r_err;

endmodule
